// File: rtl/crpa_agc_pkg.sv
// Shared types and constants for the CRPA null-former AGC loop.
// Holds the FSM state encoding, accumulator sizing and the magnitude ceiling.
package crpa_agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EVAL   = 2'd2,
    ST_SETTLE = 2'd3
  } agc_state_t;

  // Wide enough for 2^win_log2_max samples of full-scale magnitude.
  function automatic int acc_w(input int width, input int win_log2_max);
    return width + win_log2_max;
  endfunction

  // MAG_MAX: largest representable magnitude; the most negative code saturates here.
  function automatic int mag_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/crpa_null_agc_if.sv
// Sample stream into the AGC and the divider/measurement results coming out of it.
interface crpa_null_agc_if #(
  parameter int WIDTH = 12,
  parameter int DIV_W = 8
);
  logic                    valid_in;
  logic signed [WIDTH-1:0] data_in;
  logic [DIV_W-1:0]        null_div;
  logic                    div_wr;
  logic [WIDTH-1:0]        mean_out;
  logic                    mean_valid;
  logic                    sat_flag;

  modport master (
    output valid_in, data_in,
    input  null_div, div_wr, mean_out, mean_valid, sat_flag
  );

  modport slave (
    input  valid_in, data_in,
    output null_div, div_wr, mean_out, mean_valid, sat_flag
  );
endinterface

// File: rtl/crpa_agc_mag.sv
// Combinational saturating |x|: the most negative code maps to the largest positive one.
module crpa_agc_mag
  import crpa_agc_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic signed [WIDTH-1:0] x,
  output logic [WIDTH-1:0]        mag
);
  localparam logic [WIDTH-1:0] MAG_MAX  = WIDTH'(mag_max(WIDTH));
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    mag = $unsigned(x);
    if (x[WIDTH-1]) begin
      if ($unsigned(x) == MOST_NEG) mag = MAG_MAX;
      else                          mag = $unsigned(-x);
    end
  end
endmodule

// File: rtl/crpa_null_agc.sv
// Mean-magnitude AGC for one CRPA null-former channel; steps null_div by +/-1 per window.
// Optional saturation counter forcing an up-step is built when CRPA_AGC_SAT_EN is defined.
module crpa_null_agc
  import crpa_agc_pkg::*;
#(
  parameter int WIDTH        = 12,
  parameter int WIN_LOG2_MAX = 16,
  parameter int DIV_W        = 8,
  parameter int DIV_INIT     = 0,
  parameter int SETTLE       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ce,
  input  logic             enable,
  input  logic [4:0]       win_log2,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] hyst,
  input  logic [DIV_W-1:0] div_min,
  input  logic [DIV_W-1:0] div_max,
  crpa_null_agc_if.slave   agc
);
  localparam int ACC_W = acc_w(WIDTH, WIN_LOG2_MAX);
  localparam int CNT_W = (WIN_LOG2_MAX + 1 > $clog2(SETTLE + 1)) ? WIN_LOG2_MAX + 1
                                                                  : $clog2(SETTLE + 1);
  localparam logic [4:0] W_MAX = 5'(WIN_LOG2_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  agc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       w_q, w_d;
  logic [DIV_W-1:0] null_div_q, null_div_d;
  logic             div_wr_q, div_wr_d;
  logic [WIDTH-1:0] mean_q, mean_d;
  logic             mean_valid_q, mean_valid_d;

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] mean;
  logic [WIDTH:0]   thr_hi;
  logic [WIDTH-1:0] thr_lo;
  logic [4:0]       w_in;
  logic [CNT_W-1:0] win_last_cnt;
  logic             accept, win_last, sat_seen, up_req, step_up, step_dn;

  crpa_agc_mag #(.WIDTH(WIDTH)) u_mag (
    .x   (agc.data_in),
    .mag (mag)
  );

`ifdef CRPA_AGC_SAT_EN
  localparam logic [WIDTH-1:0] MAG_MAX = WIDTH'(mag_max(WIDTH));
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic             sat_flag_q, sat_flag_d;
  assign sat_seen     = (sat_cnt_q != '0);
  assign agc.sat_flag = sat_flag_q;
`else
  assign sat_seen     = 1'b0;
  assign agc.sat_flag = 1'b0;
`endif

  assign accept       = agc.valid_in & ce;
  assign w_in         = (win_log2 > W_MAX) ? W_MAX : win_log2;
  assign win_last_cnt = (CNT_W'(1) << w_q) - CNT_W'(1);
  assign win_last     = (cnt_q == win_last_cnt);
  assign mean         = WIDTH'(acc_q >> w_q);

  // Upper threshold carries one extra bit so target+hyst cannot wrap.
  assign thr_hi  = {1'b0, target} + {1'b0, hyst};
  assign thr_lo  = (target > hyst) ? (target - hyst) : '0;
  assign up_req  = sat_seen | ({1'b0, mean} > thr_hi);
  assign step_up = (div_min <= div_max) & up_req & (null_div_q < div_max);
  assign step_dn = (div_min <= div_max) & ~up_req & (mean < thr_lo) & (null_div_q > div_min);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    null_div_d   = null_div_q;
    div_wr_d     = div_wr_q;
    mean_d       = mean_q;
    mean_valid_d = mean_valid_q;
`ifdef CRPA_AGC_SAT_EN
    sat_cnt_d    = sat_cnt_q;
    sat_flag_d   = sat_flag_q;
`endif
    // With ce low every register holds, so pending pulses are stretched rather than lost.
    if (ce) begin
      div_wr_d     = 1'b0;
      mean_valid_d = 1'b0;
      if (!enable && state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef CRPA_AGC_SAT_EN
        sat_cnt_d = '0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            acc_d = '0;
            cnt_d = '0;
`ifdef CRPA_AGC_SAT_EN
            sat_cnt_d = '0;
`endif
            if (enable) begin
              state_d = ST_ACCUM;
              w_d     = w_in;
            end
          end
          ST_ACCUM: begin
            if (accept) begin
              acc_d = acc_q + ACC_W'(mag);
              cnt_d = cnt_q + CNT_W'(1);
`ifdef CRPA_AGC_SAT_EN
              if (mag == MAG_MAX) sat_cnt_d = sat_cnt_q + CNT_W'(1);
`endif
              if (win_last) state_d = ST_EVAL;
            end
          end
          ST_EVAL: begin
            mean_d       = mean;
            mean_valid_d = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
`ifdef CRPA_AGC_SAT_EN
            sat_flag_d   = sat_seen;
            sat_cnt_d    = '0;
`endif
            if (step_up) begin
              null_div_d = null_div_q + DIV_W'(1);
              div_wr_d   = 1'b1;
            end else if (step_dn) begin
              null_div_d = null_div_q - DIV_W'(1);
              div_wr_d   = 1'b1;
            end
            if ((step_up || step_dn) && SETTLE > 0) begin
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_ACCUM;
              w_d     = w_in;
            end
          end
          ST_SETTLE: begin
            if (accept) begin
              if (cnt_q == SETTLE_LAST) begin
                state_d = ST_ACCUM;
                cnt_d   = '0;
                w_d     = w_in;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      w_q          <= '0;
      null_div_q   <= DIV_W'(DIV_INIT);
      div_wr_q     <= 1'b0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
`ifdef CRPA_AGC_SAT_EN
      sat_cnt_q    <= '0;
      sat_flag_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      null_div_q   <= null_div_d;
      div_wr_q     <= div_wr_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
`ifdef CRPA_AGC_SAT_EN
      sat_cnt_q    <= sat_cnt_d;
      sat_flag_q   <= sat_flag_d;
`endif
    end
  end

  assign agc.null_div   = null_div_q;
  assign agc.div_wr     = div_wr_q;
  assign agc.mean_out   = mean_q;
  assign agc.mean_valid = mean_valid_q;
endmodule

// File: tb/tb_crpa_null_agc.sv
// Randomised scoreboard bench for crpa_null_agc against a window-level reference model.
module tb_crpa_null_agc;
  localparam int DIVI = 3;
  localparam int SETT = 4;

  typedef struct {
    int mean;
    int div;
    bit wr;
    bit sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn, ce, enable;
  logic [4:0] win_log2;
  logic [11:0] target, hyst;
  logic [7:0] div_min, div_max;

  always #5 clk = ~clk;

  crpa_null_agc_if #(.WIDTH(12), .DIV_W(8)) bus ();

  crpa_null_agc #(
    .WIDTH(12), .WIN_LOG2_MAX(16), .DIV_W(8), .DIV_INIT(DIVI), .SETTLE(SETT)
  ) dut (
    .clk(clk), .resetn(resetn), .ce(ce), .enable(enable), .win_log2(win_log2),
    .target(target), .hyst(hyst), .div_min(div_min), .div_max(div_max), .agc(bus)
  );

  int   n_cmp = 0, n_bad = 0, n_res = 0, n_wr = 0;
  bit   checking = 0, mv_prev = 0, ce_edge = 1, fresh;
  exp_t exp_q[$];
  exp_t e;

  // Reference model: 0 idle, 1 collecting window, 2 deciding, 3 discarding settle samples.
  int m_mode = 0, m_w = 0, m_div = DIVI, m_settle = 0;
  int win_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int magof(input int x);
    if (x == -2048) return 2047;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int clamp_w(input int w);
    return (w > 16) ? 16 : w;
  endfunction

  function automatic exp_t decide();
    exp_t r;
    int sum = 0, hi, lo;
    bit sat = 0, up;
    foreach (win_q[i]) begin
      sum += win_q[i];
      if (win_q[i] == 2047) sat = 1;
    end
`ifndef CRPA_AGC_SAT_EN
    sat = 0;
`endif
    r.mean = sum / (1 << m_w);
    hi = int'(target) + int'(hyst);
    lo = (int'(target) > int'(hyst)) ? int'(target) - int'(hyst) : 0;
    up = sat || (r.mean > hi);
    r.div = m_div;
    if (int'(div_min) <= int'(div_max)) begin
      if (up && m_div < int'(div_max)) r.div = m_div + 1;
      else if (!up && r.mean < lo && m_div > int'(div_min)) r.div = m_div - 1;
    end
    r.wr  = (r.div != m_div);
    r.sat = sat;
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t r;
    ce_edge = ce;
    if (!resetn) begin
      m_mode = 0;
      m_div  = DIVI;
      win_q.delete();
    end else if (ce) begin
      if (m_mode != 0 && !enable) begin
        m_mode = 0;
        win_q.delete();
      end else begin
        case (m_mode)
          0: if (enable) begin m_mode = 1; m_w = clamp_w(int'(win_log2)); end
          1: if (bus.valid_in) begin
               win_q.push_back(magof(int'(bus.data_in)));
               if (win_q.size() == (1 << m_w)) m_mode = 2;
             end
          2: begin
               r = decide();
               exp_q.push_back(r);
               m_div = r.div;
               win_q.delete();
               if (r.wr) begin m_mode = 3; m_settle = SETT; end
               else begin m_mode = 1; m_w = clamp_w(int'(win_log2)); end
             end
          default: if (bus.valid_in) begin
               m_settle--;
               if (m_settle == 0) begin m_mode = 1; m_w = clamp_w(int'(win_log2)); end
             end
        endcase
      end
    end
  end

  // Monitor: a pulse held over a ce-low edge is the same result, not a new one.
  always @(negedge clk) begin
    if (checking) begin
      fresh   = bus.mean_valid && !(mv_prev && !ce_edge);
      mv_prev = bus.mean_valid;
      chk("null_div", int'(bus.null_div), m_div);
      chk("div_wr_without_mean", int'(bus.div_wr & ~bus.mean_valid), 0);
`ifndef CRPA_AGC_SAT_EN
      chk("sat_flag_tied", int'(bus.sat_flag), 0);
`endif
      if (fresh) begin
        n_res++;
        if (bus.div_wr) n_wr++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got mean %0d, expected no result", bus.mean_out);
        end else begin
          e = exp_q.pop_front();
          chk("mean_out", int'(bus.mean_out), e.mean);
          chk("result_div", int'(bus.null_div), e.div);
          chk("div_wr", int'(bus.div_wr), int'(e.wr));
          chk("sat_flag", int'(bus.sat_flag), int'(e.sat));
        end
      end
    end
  end

  task automatic drive_const(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.data_in  = 12'(val);
    end
  endtask

  task automatic wait_model(input int mode, input int size, input int budget, input string name);
    int k = 0;
    while (!(m_mode == mode && (size < 0 || win_q.size() == size)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, int'(k < budget), 1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int k, wr0, div0, amp;
    resetn = 1'b0; ce = 1'b1; enable = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = '0;
    win_log2 = 5'd4; target = 12'd100; hyst = 12'd8;
    div_min = 8'd0; div_max = 8'd10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1;
    chk("rst_null_div", int'(bus.null_div), DIVI);
    chk("rst_div_wr", int'(bus.div_wr), 0);
    chk("rst_mean_out", int'(bus.mean_out), 0);
    chk("rst_mean_valid", int'(bus.mean_valid), 0);
    chk("rst_sat_flag", int'(bus.sat_flag), 0);
    resetn = 1'b1;
    enable = 1'b1;

    // In dead band: mean 100, divider untouched.
    drive_const(100, 60);
    chk("s1_mean", int'(bus.mean_out), 100);
    chk("s1_no_wr", n_wr, 0);
    chk("s1_div", int'(bus.null_div), DIVI);

    // Loud input: climbs one step per window up to div_max.
    drive_const(-200, 260);
    chk("s2_mean", int'(bus.mean_out), 200);
    chk("s2_div_at_max", int'(bus.null_div), 10);

    // Quiet input: descends to div_min and stops.
    div_min = 8'd2;
    drive_const(20, 320);
    chk("s3_mean", int'(bus.mean_out), 20);
    chk("s3_div_at_min", int'(bus.null_div), 2);

    // Full-scale negative input saturates to 2047.
    target = 12'd4095; hyst = 12'd0;
    drive_const(-2048, 80);
    chk("s4_mean", int'(bus.mean_out), 2047);
`ifdef CRPA_AGC_SAT_EN
    chk("s4_sat_flag", int'(bus.sat_flag), 1);
    chk("s4_stepped_up", int'(bus.null_div > 8'd2), 1);
`else
    chk("s4_sat_flag", int'(bus.sat_flag), 0);
    chk("s4_no_step", int'(bus.null_div), 2);
`endif
    drain("s4_drain");

    // Reset after 7 samples of a window.
    target = 12'd300; hyst = 12'd8; div_min = 8'd0;
    drive_const(300, 1);
    wait_model(1, 7, 200, "s5_reach_7");
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("s5_rst_div", int'(bus.null_div), DIVI);
    chk("s5_rst_mean", int'(bus.mean_out), 0);
    chk("s5_rst_mv", int'(bus.mean_valid), 0);
    chk("s5_rst_wr", int'(bus.div_wr), 0);
    chk("s5_rst_sat", int'(bus.sat_flag), 0);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.mean_valid) break;
    end
    chk("s5_first_window_latency", k, 18);
    chk("s5_mean", int'(bus.mean_out), 300);

    // Enable drop during SETTLE issues nothing.
    target = 12'd10; hyst = 12'd0;
    drive_const(500, 1);
    wait_model(3, -1, 100, "s6_reach_settle");
    @(negedge clk);
    wr0 = n_wr; div0 = int'(bus.null_div);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("s6_no_wr_on_drop", n_wr, wr0);
    chk("s6_div_held", int'(bus.null_div), div0);
    enable = 1'b1;

    // ce low mid-window with varying data: window count must freeze.
    target = 12'd500; hyst = 12'd1000;
    wait_model(1, 5, 100, "s6_reach_5");
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 12'($urandom_range(0, 400));
      @(negedge clk);
    end
    ce = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.data_in = 12'($urandom_range(0, 400));
      @(negedge clk);
    end
    drain("s6_drain");

    // Randomised traffic with shifting configuration.
    for (int c = 0; c < 1800; c++) begin
      if (c % 150 == 0) begin
        win_log2 = 5'($urandom_range(0, 3));
        target   = 12'($urandom_range(0, 600));
        hyst     = 12'($urandom_range(0, 50));
        div_min  = 8'($urandom_range(0, 5));
        div_max  = 8'($urandom_range(3, 12));
      end
      amp = ($urandom_range(0, 40) == 0) ? 2048 : $urandom_range(0, 700);
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.data_in  = 12'($urandom_range(0, 1) ? -amp : amp);
      ce           = ($urandom_range(0, 9) != 0);
      enable       = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    ce = 1'b1; enable = 1'b1;
    drive_const(0, 40);
    drain("final_drain");
    chk("results_seen", int'(n_res >= 40), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
